// File: rtl/data_mem_responder_if.sv
// Request/response bus between a core (master) and the data memory responder (slave).
// Requests carry a byte address, store data and byte enables; responses return load data or a fault.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port word memory answering one request at a time after LATENCY wait states.
// Faulted accesses (misaligned, out of range, store with no lanes) leave memory untouched.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input logic                  clk,
    input logic                  reset,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned IdxW  = ADDR_WIDTH - 2;
    localparam int unsigned Words = 2 ** IdxW;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [IdxW-1:0]   idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              err_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       mem [Words];

    logic              accept;
    logic              req_err;
    logic              commit;
    logic              c_we;
    logic [IdxW-1:0]   c_idx;
    logic [31:0]       c_wdata;
    logic [3:0]        c_be;
    logic              c_err;

    assign accept  = bus.req_valid && (state_q == StIdle);
    assign req_err = (bus.req_addr[1:0] != 2'b00)
                   || ((bus.req_addr >> ADDR_WIDTH) != 32'd0)
                   || (bus.req_we && (bus.req_be == 4'b0000));

    // With zero latency the commit happens on the accept edge, so take the live request.
    always_comb begin
        c_we    = we_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        c_err   = err_q;
        if (state_q == StIdle) begin
            c_we    = bus.req_we;
            c_idx   = bus.req_addr[ADDR_WIDTH-1:2];
            c_wdata = bus.req_wdata;
            c_be    = bus.req_be;
            c_err   = req_err;
        end
    end

    assign commit = ((state_q == StWait) && (cnt_q == 4'd0))
                  || (accept && (LATENCY == 0));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (commit) begin
            rdata_d   = (!c_err && !c_we) ? mem[c_idx] : 32'd0;
            rsp_err_d = c_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
            if (accept) begin
                we_q    <= bus.req_we;
                idx_q   <= bus.req_addr[ADDR_WIDTH-1:2];
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
                err_q   <= req_err;
            end
        end
    end

    // Memory has no reset; gating on reset keeps a held reset from committing a store.
    always_ff @(posedge clk) begin
        if (reset && commit && c_we && !c_err) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=0,
// both checked against a word-array reference model built from the access rules.
module tb_data_mem_responder;
    logic        clk;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    logic        obs_req_ready;
    logic        obs_rsp_valid;
    logic [31:0] obs_rsp_rdata;
    logic        obs_rsp_err;

    int n_total;
    int n_bad;

    logic [31:0] model [2][256];

    data_mem_responder_if ifa ();
    data_mem_responder_if ifb ();

    assign ifa.req_valid = req_valid && !sel;
    assign ifb.req_valid = req_valid && sel;
    assign ifa.req_we    = req_we;
    assign ifb.req_we    = req_we;
    assign ifa.req_addr  = req_addr;
    assign ifb.req_addr  = req_addr;
    assign ifa.req_wdata = req_wdata;
    assign ifb.req_wdata = req_wdata;
    assign ifa.req_be    = req_be;
    assign ifb.req_be    = req_be;
    assign ifa.rsp_ready = rsp_ready;
    assign ifb.rsp_ready = rsp_ready;

    assign obs_req_ready = sel ? ifb.req_ready : ifa.req_ready;
    assign obs_rsp_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
    assign obs_rsp_rdata = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
    assign obs_rsp_err   = sel ? ifb.rsp_err   : ifa.rsp_err;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_l2 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut_l0 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One full transaction on the selected instance, with `stall` cycles of response backpressure.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int stall);
        int          lat;
        int          k;
        logic        err;
        logic [31:0] exp_rd;
        logic [31:0] held;
        lat    = sel ? 0 : 2;
        err    = (addr[1:0] != 2'b00) || (addr >= 32'h400) || (we && (be == 4'b0000));
        exp_rd = (!err && !we) ? model[sel][addr[9:2]] : 32'd0;
        if (we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[sel][addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        check("req_ready_idle", {31'd0, obs_req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        k = 0;
        while (!obs_rsp_valid && k < 40) begin
            check("req_ready_busy", {31'd0, obs_req_ready}, 32'd0);
            rsp_ready = 1'($urandom % 2);
            @(posedge clk);
            #1;
            k++;
        end
        rsp_ready = 1'b0;
        check("latency", k, lat);
        check("rsp_rdata", obs_rsp_rdata, exp_rd);
        check("rsp_err", {31'd0, obs_rsp_err}, {31'd0, err});
        held = obs_rsp_rdata;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, obs_rsp_valid}, 32'd1);
            check("hold_rdata", obs_rsp_rdata, held);
            check("hold_req_ready", {31'd0, obs_req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("post_hs_valid", {31'd0, obs_rsp_valid}, 32'd0);
        check("post_hs_ready", {31'd0, obs_req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, obs_req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, obs_rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, obs_rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, obs_rsp_err}, 32'd0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        int          kind;
        n_total   = 0;
        n_bad     = 0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0;
        check_reset_outputs("rst_l2");
        sel = 1'b1;
        check_reset_outputs("rst_l0");
        reset = 1'b1;

        // Give every word a known value so the model never has to guess.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < 256; i++) do_access(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
        end

        sel = 1'b0;
        do_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_access(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("model_st_ld", model[0][4], 32'hDEADBEEF);
        do_access(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
        do_access(1'b0, 32'h10, 32'h0, 4'hF, 0);
        do_access(1'b0, 32'h12, 32'h0, 4'hF, 0);
        do_access(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
        do_access(1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 0);
        do_access(1'b0, 32'h0, 32'h0, 4'h0, 0);
        do_access(1'b0, 32'h10, 32'h0, 4'h0, 5);
        do_access(1'b0, 32'h20, 32'h0, 4'h0, 0);

        // Abandon a store mid-wait; memory and model must both keep the old word.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_wait");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        do_access(1'b0, 32'h20, 32'h0, 4'h0, 0);

        for (int i = 0; i < 200; i++) begin
            sel  = 1'($urandom % 2);
            kind = int'($urandom_range(0, 9));
            addr = (i % 2 == 0) ? 32'($urandom_range(0, 15)) << 2 : 32'($urandom_range(0, 255)) << 2;
            we   = 1'($urandom % 2);
            be   = 4'($urandom);
            if (kind == 0) addr = addr | 32'($urandom_range(1, 3));
            if (kind == 1) addr = addr | (32'h400 << $urandom_range(0, 21));
            if (kind == 2) begin
                we = 1'b1;
                be = 4'b0000;
            end
            do_access(we, addr, $urandom, be, int'($urandom_range(0, 3)));
        end

        // Zero latency with rsp_ready held high: one acceptance every second edge.
        sel       = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h44;
        req_be    = 4'h0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("l0_req_ready", {31'd0, obs_req_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("l0_rsp_valid", {31'd0, obs_rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) check("l0_rdata", obs_rsp_rdata, model[1][17]);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the number of decoded byte-address bits; storage is 2**(ADDR_WIDTH-2) 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait-state count per access; legal range is 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 selects store, 0 selects load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 The block SHALL have port req_be, input, 4 bits: store byte enables, where bit i enables byte i at bits [8i+7:8i].
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the core accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: load data.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the access faulted.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE and SHALL be independent of req_valid.
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; at that edge req_we, req_addr, req_wdata and req_be SHALL be captured.
REQ-018 A request SHALL be flagged as error if any of these hold: req_addr[1:0] is nonzero; req_addr[31:ADDR_WIDTH] is nonzero; or req_we is 1 and req_be is 0000.
REQ-019 On acceptance, the FSM SHALL go to WAIT with its counter loaded to LATENCY-1 when LATENCY is at least 1, and SHALL go directly to RESP when LATENCY is 0.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter equals 0.
REQ-021 The commit SHALL occur on the edge entering RESP:
- a non-error store updates only the enabled byte lanes of word req_addr[ADDR_WIDTH-1:2];
- a non-error load registers the full word into rsp_rdata, with req_be ignored.
REQ-022 rsp_valid SHALL first be 1 in the cycle after the edge that is LATENCY edges after the acceptance edge, i.e. LATENCY+1 cycles from acceptance.
REQ-023 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until the edge where rsp_ready is 1; that edge returns the FSM to IDLE.
REQ-024 rsp_ready asserted outside RESP SHALL be ignored.
REQ-025 For stores and for errored accesses, rsp_rdata SHALL be 0.
REQ-026 An errored access SHALL leave memory unmodified and SHALL set rsp_err to 1.
REQ-027 Back-to-back throughput: a new request SHALL be accepted no earlier than the edge after the response handshake, so the minimum period is LATENCY+2 cycles.
REQ-028 A load issued after a store to the same word SHALL return the post-store value.

Reset
REQ-029 While reset is 0, the block SHALL force: state IDLE, counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-030 Assertion of reset SHALL take effect immediately, without waiting for clk.
REQ-031 Deassertion of reset SHALL be recognised synchronously; the first acceptance is possible on the first rising edge with reset at 1.
REQ-032 Reset in WAIT SHALL abandon the transaction, with no memory write and no response.
REQ-033 Reset SHALL NOT alter memory contents.

Verification
REQ-034 Store then load, LATENCY=2:
- stimulus: store addr 0x10, wdata 0xDEADBEEF, be 1111; then load 0x10;
- required: each rsp_valid appears 3 cycles after acceptance, the load returns 0xDEADBEEF, and rsp_err is 0.
REQ-035 Byte-lane store:
- stimulus: with word 0x10 holding 0xDEADBEEF, store wdata 0x000000AA with be 0001, then load 0x10;
- required: the load returns 0xDEADBEAA.
REQ-036 Faults:
- stimulus: load addr 0x12; store addr 0x400 (ADDR_WIDTH=10); store with be 0000;
- required: each returns rsp_err 1 and rsp_rdata 0, and a load of 0x0 afterwards is unchanged.
REQ-037 Backpressure:
- stimulus: hold rsp_ready 0 for 5 cycles during a load response;
- required: rsp_valid stays 1 with rdata stable, req_ready stays 0, and a second request is accepted only after the handshake.
REQ-038 Reset mid-WAIT:
- stimulus: assert reset one cycle after accepting a store of 0x12345678 to 0x20;
- required: outputs return to reset values at once, and a later load of 0x20 returns the old value.
REQ-039 LATENCY=0:
- stimulus: issue a load;
- required: rsp_valid is 1 in the cycle after acceptance, and with rsp_ready held at 1 a new request is accepted every 2 cycles.
